// File: rtl/msdf_otf_stream_converter_pkg.sv
// Shared definitions for the MSDF on-the-fly stream converter:
// encoding names, the digit decoder and the frame FSM states.
package msdf_otf_stream_converter_pkg;

    localparam string ENC_SIGNED_DIGIT = "signed-digit";
    localparam string ENC_BORROW_SAVE  = "borrow-save";

    // Decoded digit: value in {-1, 0, +1} plus an invalid-code marker
    typedef struct packed {
        logic signed [1:0] val;
        logic              inv;
    } digit_dec_t;

    typedef enum logic {
        ST_ACCUM    = 1'b0,
        ST_WAIT_OUT = 1'b1
    } state_t;

    // Signed-digit: 00=0, 01=+1, 11=-1, 10 invalid (read as 0).
    // Borrow-save {p,n}: value p-n, every code is legal.
    function automatic digit_dec_t decode_digit(input logic [1:0] code,
                                                input logic       borrow_save);
        digit_dec_t d;
        d.val = 2'sd0;
        d.inv = 1'b0;
        if (borrow_save) begin
            case (code)
                2'b10:   d.val = 2'sd1;
                2'b01:   d.val = -2'sd1;
                default: d.val = 2'sd0;
            endcase
        end else begin
            case (code)
                2'b01:   d.val = 2'sd1;
                2'b11:   d.val = -2'sd1;
                2'b10:   d.inv = 1'b1;
                default: d.val = 2'sd0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/msdf_otf_stream_converter_core.sv
// Combinational OTF step: decodes one digit and produces the next Q/QM
// for digit index j (bit position PRECISION-1-j). When j has reached
// PRECISION the registers pass through unchanged.
module msdf_otf_stream_converter_core
    import msdf_otf_stream_converter_pkg::*;
#(
    parameter int    PRECISION     = 64,
    parameter string ENCODING_MODE = ENC_SIGNED_DIGIT,
    parameter int    CNT_W         = $clog2(PRECISION + 1)
) (
    input  logic [PRECISION:0] q,
    input  logic [PRECISION:0] qm,
    input  logic [1:0]         digit,
    input  logic [CNT_W-1:0]   j,
    output logic [PRECISION:0] q_nxt,
    output logic [PRECISION:0] qm_nxt,
    output logic               inv
);

    localparam logic USE_BS = (ENCODING_MODE == ENC_BORROW_SAVE);

    digit_dec_t         dec;
    logic [PRECISION:0] mask;
    logic               active;

    assign dec    = decode_digit(digit, USE_BS);
    assign inv    = dec.inv;
    assign active = (j != CNT_W'(PRECISION));

    // One-hot mask selecting bit PRECISION-1-j
    always_comb begin
        mask = '0;
        for (int i = 0; i < PRECISION; i++) begin
            if (int'(j) == PRECISION - 1 - i) mask[i] = 1'b1;
        end
    end

    // OTF append: Q tracks the exact value, QM tracks value minus one ulp
    always_comb begin
        q_nxt  = q;
        qm_nxt = qm;
        if (active) begin
            if (dec.val == 2'sd1) begin
                q_nxt  = q | mask;
                qm_nxt = q;
            end else if (dec.val == -2'sd1) begin
                q_nxt  = qm | mask;
            end else begin
                qm_nxt = qm | mask;
            end
        end
    end

endmodule

// File: rtl/msdf_otf_stream_converter.sv
// Framed MSDF-to-two's-complement converter with valid/ready on both
// sides, a one-deep output register and a pending slot for a frame that
// completes while the output is still occupied.
module msdf_otf_stream_converter
    import msdf_otf_stream_converter_pkg::*;
#(
    parameter int    PRECISION     = 64,
    parameter string ENCODING_MODE = ENC_SIGNED_DIGIT,
    parameter int    CNT_W         = $clog2(PRECISION + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_digit,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PRECISION:0] out_data,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_ovf,
    output logic               out_err
);

    localparam logic [PRECISION:0] QM_INIT = {1'b1, {PRECISION{1'b0}}};

    state_t             state_q, state_d;
    logic [PRECISION:0] q_q, qm_q, q_nxt, qm_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_fin;
    logic               ovf_q, err_q, ovf_fin, err_fin, inv;
    logic               at_max, accept;
    logic               load_new, load_pend, load_from_pend, drop_valid;

    logic [PRECISION:0] pend_data;
    logic [CNT_W-1:0]   pend_count;
    logic               pend_ovf, pend_err;

    msdf_otf_stream_converter_core #(
        .PRECISION    (PRECISION),
        .ENCODING_MODE(ENCODING_MODE),
        .CNT_W        (CNT_W)
    ) u_core (
        .q     (q_q),
        .qm    (qm_q),
        .digit (in_digit),
        .j     (cnt_q),
        .q_nxt (q_nxt),
        .qm_nxt(qm_nxt),
        .inv   (inv)
    );

    assign accept  = in_valid && in_ready;
    assign at_max  = (cnt_q == CNT_W'(PRECISION));
    assign cnt_fin = at_max ? cnt_q : cnt_q + CNT_W'(1);
    assign ovf_fin = ovf_q | at_max;
    assign err_fin = err_q | inv;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        state_q <= ST_ACCUM;
        else if (i_clr) state_q <= ST_ACCUM;
        else            state_q <= state_d;
    end

    // Next state, input handshake and output-register load decisions
    always_comb begin
        state_d        = state_q;
        in_ready       = 1'b0;
        load_new       = 1'b0;
        load_pend      = 1'b0;
        load_from_pend = 1'b0;
        drop_valid     = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    if (!out_valid || out_ready) begin
                        load_new = 1'b1;
                    end else begin
                        load_pend = 1'b1;
                        state_d   = ST_WAIT_OUT;
                    end
                end else if (out_valid && out_ready) begin
                    drop_valid = 1'b1;
                end
            end
            ST_WAIT_OUT: begin
                if (out_ready) begin
                    load_from_pend = 1'b1;
                    state_d        = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // Frame accumulation: Q/QM, digit count and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            qm_q  <= QM_INIT;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else if (i_clr || (accept && in_last)) begin
            q_q   <= '0;
            qm_q  <= QM_INIT;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else if (accept) begin
            q_q   <= q_nxt;
            qm_q  <= qm_nxt;
            cnt_q <= cnt_fin;
            ovf_q <= ovf_fin;
            err_q <= err_fin;
        end
    end

    // Pending slot for a frame completed while the output was blocked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data  <= '0;
            pend_count <= '0;
            pend_ovf   <= 1'b0;
            pend_err   <= 1'b0;
        end else if (i_clr) begin
            pend_data  <= '0;
            pend_count <= '0;
            pend_ovf   <= 1'b0;
            pend_err   <= 1'b0;
        end else if (load_pend) begin
            pend_data  <= q_nxt;
            pend_count <= cnt_fin;
            pend_ovf   <= ovf_fin;
            pend_err   <= err_fin;
        end
    end

    // Output register: loads a fresh or pending result, drops on drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
        end else if (i_clr) begin
            out_valid <= 1'b0;
        end else if (load_new) begin
            out_valid <= 1'b1;
            out_data  <= q_nxt;
            out_count <= cnt_fin;
            out_ovf   <= ovf_fin;
            out_err   <= err_fin;
        end else if (load_from_pend) begin
            out_valid <= 1'b1;
            out_data  <= pend_data;
            out_count <= pend_count;
            out_ovf   <= pend_ovf;
            out_err   <= pend_err;
        end else if (drop_valid) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_msdf_otf_stream_converter.sv
// Directed bench for msdf_otf_stream_converter at PRECISION=8, with a
// signed-digit instance and a borrow-save instance sharing the framing.
module tb_msdf_otf_stream_converter;

    localparam int P  = 8;
    localparam int CW = 4;

    localparam logic [1:0] DP   = 2'b01;  // +1 signed-digit
    localparam logic [1:0] DM   = 2'b11;  // -1 signed-digit
    localparam logic [1:0] DZ   = 2'b00;  //  0
    localparam logic [1:0] DBAD = 2'b10;  // invalid signed-digit code

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, i_clr, in_valid, in_last, out_ready;
    logic [1:0]    in_digit, in_digit_bs;
    logic          in_ready, out_valid, out_ovf, out_err;
    logic [P:0]    out_data;
    logic [CW-1:0] out_count;
    logic          in_ready_bs, out_valid_bs, out_ovf_bs, out_err_bs;
    logic [P:0]    out_data_bs;
    logic [CW-1:0] out_count_bs;

    int n_total = 0;
    int n_pass  = 0;

    msdf_otf_stream_converter #(
        .PRECISION(P), .ENCODING_MODE("signed-digit"), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .i_clr(i_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_ovf(out_ovf), .out_err(out_err)
    );

    msdf_otf_stream_converter #(
        .PRECISION(P), .ENCODING_MODE("borrow-save"), .CNT_W(CW)
    ) dut_bs (
        .clk(clk), .rst(rst), .i_clr(i_clr),
        .in_valid(in_valid), .in_ready(in_ready_bs), .in_digit(in_digit_bs), .in_last(in_last),
        .out_valid(out_valid_bs), .out_ready(out_ready), .out_data(out_data_bs),
        .out_count(out_count_bs), .out_ovf(out_ovf_bs), .out_err(out_err_bs)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one digit and holds it until accepted (bounded wait)
    task automatic send(input logic [1:0] d, input logic [1:0] dbs, input logic last);
        int n;
        n           = 0;
        in_valid    = 1'b1;
        in_digit    = d;
        in_digit_bs = dbs;
        in_last     = last;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; in_digit = DZ; in_digit_bs = DZ;
        #2;
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_in_ready_bs", 32'(in_ready_bs), 32'd1);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_out_data",  32'(out_data),    32'h000);
        chk("rst_out_count", 32'(out_count),   32'd0);
        chk("rst_out_ovf",   32'(out_ovf),     32'd0);
        chk("rst_out_err",   32'(out_err),     32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        // +1, -1, 0, +1 -> 0.3125
        send(DP, DP, 1'b0); send(DM, DM, 1'b0); send(DZ, DZ, 1'b0);
        chk("t1_pre_last_valid", 32'(out_valid), 32'd0);
        send(DP, DP, 1'b1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data",  32'(out_data),  32'h050);
        chk("t1_count", 32'(out_count), 32'd4);
        chk("t1_ovf",   32'(out_ovf),   32'd0);
        chk("t1_err",   32'(out_err),   32'd0);
        drain();
        chk("t1_drained", 32'(out_valid), 32'd0);

        // -1, 0, 0, +1 -> -0.4375
        send(DM, DM, 1'b0); send(DZ, DZ, 1'b0); send(DZ, DZ, 1'b0); send(DP, DP, 1'b1);
        chk("t2_data",  32'(out_data),  32'h190);
        chk("t2_count", 32'(out_count), 32'd4);
        drain();

        // 10 x +1: saturates at 8 digits
        for (int i = 0; i < 10; i++) send(DP, DP, logic'(i == 9));
        chk("t3_data",  32'(out_data),  32'h0FF);
        chk("t3_count", 32'(out_count), 32'd8);
        chk("t3_ovf",   32'(out_ovf),   32'd1);
        chk("t3_err",   32'(out_err),   32'd0);
        drain();

        // Invalid signed-digit code vs. equivalent borrow-save frame
        send(DP, 2'b10, 1'b0); send(DBAD, 2'b00, 1'b0); send(DP, 2'b10, 1'b1);
        chk("t4_sd_data",  32'(out_data),     32'h0A0);
        chk("t4_sd_err",   32'(out_err),      32'd1);
        chk("t4_bs_valid", 32'(out_valid_bs), 32'd1);
        chk("t4_bs_data",  32'(out_data_bs),  32'h0A0);
        chk("t4_bs_err",   32'(out_err_bs),   32'd0);
        chk("t4_bs_count", 32'(out_count_bs), 32'd3);
        chk("t4_bs_ovf",   32'(out_ovf_bs),   32'd0);
        drain();

        // Backpressure: two frames with out_ready low
        send(DP, DP, 1'b0); send(DP, DP, 1'b0); send(DP, DP, 1'b1);
        chk("t5_a_data", 32'(out_data), 32'h0E0);
        send(DM, DM, 1'b0); send(DM, DM, 1'b0); send(DM, DM, 1'b1);
        chk("t5_wait_in_ready", 32'(in_ready),  32'd0);
        chk("t5_hold_data",     32'(out_data),  32'h0E0);
        chk("t5_hold_valid",    32'(out_valid), 32'd1);
        step();
        chk("t5_hold_data2",    32'(out_data),  32'h0E0);
        chk("t5_hold_count2",   32'(out_count), 32'd3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t5_b_data",     32'(out_data),  32'h120);
        chk("t5_b_valid",    32'(out_valid), 32'd1);
        chk("t5_b_in_ready", 32'(in_ready),  32'd1);
        drain();
        chk("t5_drained", 32'(out_valid), 32'd0);

        // Drain and completion in the same cycle, back-to-back frames
        out_ready = 1'b1;
        send(DP, DP, 1'b1);
        chk("t6_a_data", 32'(out_data), 32'h080);
        send(DM, DM, 1'b1);
        chk("t6_b_data",     32'(out_data), 32'h180);
        chk("t6_b_in_ready", 32'(in_ready), 32'd1);
        step();
        out_ready = 1'b0;
        chk("t6_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-frame with a result held
        send(DP, DP, 1'b1);
        send(DP, DP, 1'b0); send(DP, DP, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("t7_rst_valid",    32'(out_valid), 32'd0);
        chk("t7_rst_data",     32'(out_data),  32'h000);
        chk("t7_rst_count",    32'(out_count), 32'd0);
        chk("t7_rst_in_ready", 32'(in_ready),  32'd1);
        #1 rst = 1'b0;
        step(); step();
        chk("t7_no_valid", 32'(out_valid), 32'd0);
        send(DP, DP, 1'b0); send(DP, DP, 1'b1);
        chk("t7_fresh_data",  32'(out_data),  32'h0C0);
        chk("t7_fresh_count", 32'(out_count), 32'd2);

        // i_clr drops a held result and a partial frame
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        chk("t8_clr_valid",    32'(out_valid), 32'd0);
        chk("t8_clr_in_ready", 32'(in_ready),  32'd1);
        send(DP, DP, 1'b0);
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        send(DM, DM, 1'b1);
        chk("t8_after_clr_data",  32'(out_data),  32'h180);
        chk("t8_after_clr_count", 32'(out_count), 32'd1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
